// File: rtl/log_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : log_serializer_if
// Brief    : Sample, host-write and log-bus signal bundle for log_serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface log_serializer_if #(
    parameter int N_CHAN    = 8,
    parameter int W_LCHAN   = 5,
    parameter int W_LDATA   = 18,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 5,
    parameter int W_WR_DATA = 49
);
    logic [N_CHAN-1:0]         dv_in;
    logic [N_CHAN*W_LDATA-1:0] data_in;
    logic                      wr_en_in;
    logic [W_WR_ADDR-1:0]      wr_addr_in;
    logic [W_WR_CHAN-1:0]      wr_chan_in;
    logic [W_WR_DATA-1:0]      wr_data_in;
    logic                      log_dv_out;
    logic [W_LCHAN-1:0]        log_chan_out;
    logic [W_LDATA-1:0]        log_data_out;
    logic [N_CHAN-1:0]         ovf_out;

    modport master (
        output dv_in, data_in, wr_en_in, wr_addr_in, wr_chan_in, wr_data_in,
        input  log_dv_out, log_chan_out, log_data_out, ovf_out
    );

    modport slave (
        input  dv_in, data_in, wr_en_in, wr_addr_in, wr_chan_in, wr_data_in,
        output log_dv_out, log_chan_out, log_data_out, ovf_out
    );
endinterface
`default_nettype wire

// File: rtl/log_serializer.sv
`default_nettype none
// ============================================================================
// Module   : log_serializer
// Brief    : Round-robin serializer of per-channel PID samples onto a log bus.
// Revision : 1.0 - initial release
// ============================================================================
module log_serializer #(
    parameter int                   N_CHAN       = 8,
    parameter int                   W_LCHAN      = 5,
    parameter int                   W_LDATA      = 18,
    parameter int                   W_WR_ADDR    = 16,
    parameter int                   W_WR_CHAN    = 5,
    parameter int                   W_WR_DATA    = 49,
    parameter logic [W_WR_ADDR-1:0] LOG_EN_ADDR  = 16'h0040,
    parameter logic [W_WR_ADDR-1:0] OVF_CLR_ADDR = 16'h0041
) (
    input  wire logic       pid_clk_in,
    input  wire logic       rst_n_in,
    log_serializer_if.slave bus
);
    localparam logic [W_LCHAN-1:0] c_LAST_CHAN = W_LCHAN'(N_CHAN - 1);

    logic [N_CHAN-1:0]  r_enable;
    logic [N_CHAN-1:0]  r_pending;
    logic [N_CHAN-1:0]  r_ovf;
    logic [W_LDATA-1:0] r_hold [N_CHAN];
    logic [W_LCHAN-1:0] r_last_grant;
    logic               r_log_dv;
    logic [W_LCHAN-1:0] r_log_chan;
    logic [W_LDATA-1:0] r_log_data;

    logic               w_found_hi, w_found_lo, w_found;
    logic [W_LCHAN-1:0] w_grant_hi, w_grant_lo, w_grant;
    logic [N_CHAN-1:0]  w_grant_vec;
    logic [W_LDATA-1:0] w_grant_data;
    logic               w_en_wr, w_clr_wr;
    logic [N_CHAN-1:0]  w_en_hit, w_disable, w_capture, w_ovf_set;
    logic [N_CHAN-1:0]  w_pending_nxt, w_enable_nxt;

    assign w_en_wr  = bus.wr_en_in && (bus.wr_addr_in == LOG_EN_ADDR);
    assign w_clr_wr = bus.wr_en_in && (bus.wr_addr_in == OVF_CLR_ADDR);

    // Rotating priority: channels above last_grant first, then wrap to the rest.
    always_comb begin
        w_found_hi = 1'b0;
        w_grant_hi = '0;
        w_found_lo = 1'b0;
        w_grant_lo = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (r_pending[k]) begin
                if (W_LCHAN'(k) > r_last_grant) begin
                    if (!w_found_hi) begin
                        w_found_hi = 1'b1;
                        w_grant_hi = W_LCHAN'(k);
                    end
                end else if (!w_found_lo) begin
                    w_found_lo = 1'b1;
                    w_grant_lo = W_LCHAN'(k);
                end
            end
        end
    end

    assign w_found = w_found_hi || w_found_lo;
    assign w_grant = w_found_hi ? w_grant_hi : w_grant_lo;

    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (w_grant_vec[k]) begin
                w_grant_data = r_hold[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
            // Out-of-range channel numbers simply match no decoder slot.
            assign w_en_hit[k]      = w_en_wr && (bus.wr_chan_in == W_WR_CHAN'(k));
            assign w_enable_nxt[k]  = w_en_hit[k] ? bus.wr_data_in[0] : r_enable[k];
            assign w_disable[k]     = w_en_hit[k] && !bus.wr_data_in[0];
            assign w_grant_vec[k]   = w_found && (w_grant == W_LCHAN'(k));
            assign w_capture[k]     = bus.dv_in[k] && r_enable[k] && !w_disable[k];
            // A grant in the same cycle drains the old sample, so no data is lost.
            assign w_ovf_set[k]     = w_capture[k] && r_pending[k] && !w_grant_vec[k];
            assign w_pending_nxt[k] = !w_disable[k] &&
                                      (w_capture[k] || (r_pending[k] && !w_grant_vec[k]));

            always_ff @(posedge pid_clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_hold[k] <= '0;
                end else if (w_capture[k]) begin
                    r_hold[k] <= bus.data_in[k*W_LDATA +: W_LDATA];
                end
            end
        end
    endgenerate

    always_ff @(posedge pid_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_enable     <= '1;
            r_pending    <= '0;
            r_ovf        <= '0;
            r_last_grant <= c_LAST_CHAN;
            r_log_dv     <= 1'b0;
            r_log_chan   <= '0;
            r_log_data   <= '0;
        end else begin
            r_enable  <= w_enable_nxt;
            r_pending <= w_pending_nxt;
            r_ovf     <= (w_clr_wr ? '0 : r_ovf) | w_ovf_set;
            r_log_dv  <= w_found;
            if (w_found) begin
                r_last_grant <= w_grant;
                r_log_chan   <= w_grant;
                r_log_data   <= w_grant_data;
            end
        end
    end

    assign bus.log_dv_out   = r_log_dv;
    assign bus.log_chan_out = r_log_chan;
    assign bus.log_data_out = r_log_data;
    assign bus.ovf_out      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_log_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_serializer
// Brief    : Directed bench for log_serializer with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_log_serializer;
    localparam int N = 8;
    localparam int W = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    log_serializer_if #(.N_CHAN(N), .W_LCHAN(5), .W_LDATA(W),
                        .W_WR_ADDR(16), .W_WR_CHAN(5), .W_WR_DATA(49)) bus ();

    log_serializer #(.N_CHAN(N), .W_LCHAN(5), .W_LDATA(W),
                     .W_WR_ADDR(16), .W_WR_CHAN(5), .W_WR_DATA(49),
                     .LOG_EN_ADDR(16'h0040), .OVF_CLR_ADDR(16'h0041)) dut (
        .pid_clk_in (clk),
        .rst_n_in   (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference state: what the log bus must show after the next rising edge.
    bit         m_pend [N];
    bit         m_en   [N];
    logic [W-1:0] m_hold [N];
    logic [N-1:0] m_ovf;
    int         m_last;
    logic       m_dv;
    int         m_chan;
    logic [W-1:0] m_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 1'b0;
            m_en[k]   = 1'b1;
            m_hold[k] = '0;
        end
        m_ovf  = '0;
        m_last = N - 1;
        m_dv   = 1'b0;
        m_chan = 0;
        m_data = '0;
    endtask

    // Applies the rules for one edge, using the inputs that edge will sample.
    task automatic model_step();
        bit found;
        int g;
        int dis;
        bit pend_old [N];
        found = 1'b0;
        g     = 0;
        dis   = -1;
        pend_old = m_pend;
        for (int i = 1; i <= N; i++) begin
            if (!found && m_pend[(m_last + i) % N]) begin
                found = 1'b1;
                g     = (m_last + i) % N;
            end
        end
        m_dv = found;
        if (found) begin
            m_chan    = g;
            m_data    = m_hold[g];
            m_last    = g;
            m_pend[g] = 1'b0;
        end
        if (bus.wr_en_in && bus.wr_addr_in == 16'h0041) m_ovf = '0;
        if (bus.wr_en_in && bus.wr_addr_in == 16'h0040 && int'(bus.wr_chan_in) < N
            && !bus.wr_data_in[0]) dis = int'(bus.wr_chan_in);
        for (int k = 0; k < N; k++) begin
            if (bus.dv_in[k] && m_en[k] && k != dis) begin
                if (pend_old[k] && !(found && g == k)) m_ovf[k] = 1'b1;
                m_hold[k] = bus.data_in[k*W +: W];
                m_pend[k] = 1'b1;
            end
        end
        if (bus.wr_en_in && bus.wr_addr_in == 16'h0040 && int'(bus.wr_chan_in) < N)
            m_en[bus.wr_chan_in] = bus.wr_data_in[0];
        if (dis >= 0) m_pend[dis] = 1'b0;
    endtask

    // Compare, then advance the model with the inputs held across the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                chk("model.dv",   64'(bus.log_dv_out),   64'(m_dv));
                chk("model.chan", 64'(bus.log_chan_out), 64'(m_chan));
                chk("model.data", 64'(bus.log_data_out), 64'(m_data));
                chk("model.ovf",  64'(bus.ovf_out),      64'(m_ovf));
                model_step();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: no summary after 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic dv, input int chan,
                              input logic [W-1:0] data, input logic [N-1:0] ovf);
        chk({tag, ".dv"},   64'(bus.log_dv_out),   64'(dv));
        chk({tag, ".chan"}, 64'(bus.log_chan_out), 64'(chan));
        chk({tag, ".data"}, 64'(bus.log_data_out), 64'(data));
        chk({tag, ".ovf"},  64'(bus.ovf_out),      64'(ovf));
    endtask

    task automatic set_slice(input int k, input logic [W-1:0] v);
        bus.data_in[k*W +: W] = v;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [4:0] chan, input logic [48:0] data);
        bus.wr_en_in   = 1'b1;
        bus.wr_addr_in = addr;
        bus.wr_chan_in = chan;
        bus.wr_data_in = data;
        tick();
        bus.wr_en_in   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_release.dv", 64'(bus.log_dv_out), 64'(0));
    endtask

    initial begin
        bus.dv_in      = '0;
        bus.data_in    = '0;
        bus.wr_en_in   = 1'b0;
        bus.wr_addr_in = '0;
        bus.wr_chan_in = '0;
        bus.wr_data_in = '0;
        repeat (3) tick();
        expect_out("reset", 1'b0, 0, '0, '0);
        rst_n = 1'b1;
        tick();
        chk("first_edge.dv", 64'(bus.log_dv_out), 64'(0));

        // Single sample on channel 2.
        set_slice(2, 18'h2ABCD);
        bus.dv_in = 8'h04;
        tick();
        bus.dv_in = 8'h00;
        tick();
        expect_out("single", 1'b1, 2, 18'h2ABCD, 8'h00);
        tick();
        expect_out("single_hold", 1'b0, 2, 18'h2ABCD, 8'h00);

        // Burst on all channels drains 0..7 in order.
        do_reset();
        for (int k = 0; k < N; k++) set_slice(k, W'(k));
        bus.dv_in = 8'hFF;
        tick();
        bus.dv_in = 8'h00;
        for (int i = 0; i < N; i++) begin
            tick();
            expect_out($sformatf("burst%0d", i), 1'b1, i, W'(i), 8'h00);
        end
        tick();
        chk("burst_end.dv", 64'(bus.log_dv_out), 64'(0));

        // Overwrite of pending channel 7.
        do_reset();
        for (int k = 0; k < N; k++) set_slice(k, W'(k));
        bus.dv_in = 8'hFF;
        tick();
        set_slice(7, 18'h3FFFF);
        bus.dv_in = 8'h80;
        tick();
        bus.dv_in = 8'h00;
        expect_out("ovw0", 1'b1, 0, 18'h0, 8'h80);
        for (int i = 1; i < N; i++) begin
            tick();
            expect_out($sformatf("ovw%0d", i), 1'b1, i, (i == 7) ? 18'h3FFFF : W'(i), 8'h80);
        end
        tick();
        expect_out("ovw_idle", 1'b0, 7, 18'h3FFFF, 8'h80);
        wr(16'h0041, 5'd0, 49'd0);
        expect_out("ovf_clr", 1'b0, 7, 18'h3FFFF, 8'h00);

        // Channel enable control.
        do_reset();
        wr(16'h0040, 5'd3, 49'd0);
        set_slice(3, 18'h00099);
        bus.dv_in = 8'h08;
        tick();
        bus.dv_in = 8'h00;
        tick();
        chk("disabled.dv", 64'(bus.log_dv_out), 64'(0));
        tick();
        chk("disabled2.dv", 64'(bus.log_dv_out), 64'(0));
        wr(16'h0040, 5'd3, 49'd1);
        set_slice(3, 18'h01234);
        bus.dv_in = 8'h08;
        tick();
        bus.dv_in = 8'h00;
        tick();
        expect_out("enabled", 1'b1, 3, 18'h01234, 8'h00);
        wr(16'h0040, 5'd9, 49'd0);
        wr(16'h0055, 5'd1, 49'd0);
        set_slice(1, 18'h00011);
        set_slice(3, 18'h00055);
        bus.dv_in = 8'h0A;
        tick();
        bus.dv_in = 8'h00;
        tick();
        expect_out("chan9_ign_a", 1'b1, 1, 18'h00011, 8'h00);
        tick();
        expect_out("chan9_ign_b", 1'b1, 3, 18'h00055, 8'h00);

        // Capture in the same cycle channel 1 is granted.
        do_reset();
        set_slice(1, 18'h0000A);
        bus.dv_in = 8'h02;
        tick();
        set_slice(1, 18'h0000B);
        tick();
        bus.dv_in = 8'h00;
        expect_out("same_old", 1'b1, 1, 18'h0000A, 8'h00);
        tick();
        expect_out("same_new", 1'b1, 1, 18'h0000B, 8'h00);
        tick();
        chk("same_end.dv", 64'(bus.log_dv_out), 64'(0));

        // Asynchronous reset with five channels pending.
        do_reset();
        for (int k = 0; k < 5; k++) set_slice(k, W'(18'h100 + k));
        bus.dv_in = 8'h1F;
        tick();
        set_slice(0, 18'h00200);
        set_slice(4, 18'h00300);
        bus.dv_in = 8'h11;
        tick();
        bus.dv_in = 8'h00;
        expect_out("pre_rst", 1'b1, 0, 18'h00100, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, 0, 18'h0, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel1.dv", 64'(bus.log_dv_out), 64'(0));
        tick();
        chk("rst_rel2.dv", 64'(bus.log_dv_out), 64'(0));
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/log_serializer.md
LOG_SERIALIZER -- requirements
Module: log_serializer

Interface
REQ-001 SHALL have parameter N_CHAN, default 8: number of PID data sources feeding the log bus.
REQ-002 SHALL have parameter W_LCHAN, default 5: log channel index width.
REQ-003 SHALL have parameter W_LDATA, default 18: log sample width.
REQ-004 SHALL have parameters W_WR_ADDR 16, W_WR_CHAN 5, W_WR_DATA 49: host write-request field widths.
REQ-005 SHALL have parameters LOG_EN_ADDR, default 16'h0040 (per-channel enable request), and OVF_CLR_ADDR, default 16'h0041 (overflow clear request).
REQ-006 SHALL use one clock and an asynchronous, active-low reset; the port list below starts with both.
REQ-007 pid_clk_in  input  1  system clock; every flop is clocked on its rising edge.
REQ-008 rst_n_in  input  1  asynchronous active-low reset.
REQ-009 dv_in  input  N_CHAN  per-source sample strobe; bit k qualifies slice k of data_in.
REQ-010 data_in  input  N_CHAN*W_LDATA  packed samples; channel k occupies bits [k*W_LDATA +: W_LDATA].
REQ-011 wr_en_in, wr_addr_in, wr_chan_in, wr_data_in  input  1/W_WR_ADDR/W_WR_CHAN/W_WR_DATA  host write request; valid for one cycle.
REQ-012 log_dv_out  output  1  single-cycle log strobe.
REQ-013 log_chan_out  output  W_LCHAN  channel index of the current log word.
REQ-014 log_data_out  output  W_LDATA  sample carried by the current log word.
REQ-015 ovf_out  output  N_CHAN  sticky per-channel overwrite flags.

Function
REQ-016 SHALL keep one hold register and one pending bit per channel.
REQ-017 dv_in[k] with channel k enabled SHALL load hold[k] with slice k and set pending[k] at that edge.
REQ-018 dv_in[k] while pending[k] is set and k is not granted that cycle SHALL overwrite hold[k] (latest sample wins) and set ovf_out[k].
REQ-019 SHALL run a round-robin arbiter: each cycle it grants the first pending channel searching upward from last_grant+1 modulo N_CHAN; there is at most one grant per cycle.
REQ-020 A grant SHALL, at the next edge, drive log_dv_out=1, log_chan_out=k, log_data_out=hold[k], clear pending[k], and set last_grant=k.
REQ-021 A cycle with no grant SHALL leave log_dv_out=0 and hold log_chan_out/log_data_out at their previous values.
REQ-022 Latency: a sample captured at edge E on an idle bus SHALL appear on the log bus at edge E+1.
REQ-023 dv_in[k] in the same cycle that k is granted SHALL output the old hold[k], then capture the new sample with pending[k] still set; ovf_out[k] is not set.
REQ-024 Worst-case wait for a pending channel SHALL be N_CHAN cycles.
REQ-025 wr_en_in with wr_addr_in==LOG_EN_ADDR and wr_chan_in<N_CHAN SHALL set enable[wr_chan_in]=wr_data_in[0]; a request with wr_chan_in>=N_CHAN is ignored.
REQ-026 Disabling channel k SHALL clear pending[k] at that edge, and later dv_in[k] SHALL be ignored; a grant already issued is unaffected.
REQ-027 wr_en_in with wr_addr_in==OVF_CLR_ADDR SHALL clear all ovf_out bits; a new overflow in the same cycle wins and sets its bit.
REQ-028 Any other wr_addr_in value SHALL be ignored.

Reset
REQ-029 Reset assertion SHALL immediately force log_dv_out=0, log_chan_out=0, log_data_out=0, ovf_out=0, all pending=0, all hold=0, enable=all ones, and last_grant=N_CHAN-1, so channel 0 has first priority.
REQ-030 Reset mid-operation SHALL discard all pending samples; no log word is emitted in the first edge after release.

Verification
REQ-031 Single sample: dv_in=8'h04, slice 2=18'h2ABCD -> next cycle log_dv_out=1, log_chan_out=2, log_data_out=18'h2ABCD, ovf_out=0.
REQ-032 Burst: dv_in=8'hFF for one cycle, slice k=k -> log_dv_out high for 8 consecutive cycles, channels 0..7 in order, data 0..7.
REQ-033 Overwrite: dv_in=8'hFF, then next cycle dv_in=8'h80 with slice 7=18'h3FFFF -> channel 7 emits 18'h3FFFF once and ovf_out=8'h80; an OVF_CLR_ADDR write then returns ovf_out to 0.
REQ-034 Enable: write LOG_EN_ADDR, chan 3, data 0, then dv_in=8'h08 -> no log word; write data 1, then dv_in=8'h08 -> word on chan 3; write chan 9 -> no state change.
REQ-035 Same-cycle grant and capture: channel 1 pending, dv_in[1] in its grant cycle -> old value emitted, new value emitted on the next grant of channel 1, ovf_out[1]=0.
REQ-036 Reset: assert rst_n_in=0 with 5 channels pending -> outputs 0 immediately; after release with dv_in=0, log_dv_out stays 0.
